// File: rtl/if_pc_stage.sv
// Fetch-stage state for the pipelined MIPS core: program counter, IF/ID register,
// exception/eret redirect, end-of-text halt, fetch-address fault tagging and a fetch counter.
module if_pc_stage #(
    parameter logic [31:0] TEXT_STARTADDR = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE        = 32'h0000_1000,
    parameter logic [31:0] EXC_HANDLER    = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc8,
    output logic        ifid_valid,
    output logic        ifid_adel,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    // One extra bit so a text segment ending at 2^32 still compares correctly.
    localparam logic [32:0] TextEnd = {1'b0, TEXT_STARTADDR} + {1'b0, IM_SIZE};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;
    logic [31:0] count_q, count_d;

    logic at_end;
    logic fetch_fault;
    logic redirect;
    logic halt_hold;

    assign at_end      = ({1'b0, pc_q} >= TextEnd);
    assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_STARTADDR);
    assign redirect    = exc_req || eret;
    // The edge that detects end-of-text already behaves as a halted edge.
    assign halt_hold   = (state_q == StHalt) || at_end;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = StRun;
        end else if (state_q == StRun && at_end) begin
            state_d = StHalt;
        end
    end

    // State-decoded outputs
    always_comb begin
        halted = (state_q == StHalt);
    end

    // PC and IF/ID next-state in edge priority order
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;
        adel_d    = adel_q;
        count_d   = count_q;
        if (redirect) begin
            pc_d      = exc_req ? EXC_HANDLER : epc;
            instr_d   = 32'h0;
            ifid_pc_d = pc_q;
            valid_d   = 1'b0;
            adel_d    = 1'b0;
        end else if (halt_hold) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (!stall) begin
            pc_d      = npc;
            ifid_pc_d = pc_q;
            valid_d   = 1'b1;
            instr_d   = fetch_fault ? 32'h0 : instr_in;
            adel_d    = fetch_fault;
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= TEXT_STARTADDR;
            instr_q   <= 32'h0;
            ifid_pc_q <= 32'h0;
            valid_q   <= 1'b0;
            adel_q    <= 1'b0;
            count_q   <= 32'h0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
            adel_q    <= adel_d;
            count_q   <= count_d;
        end
    end

    assign pc          = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_pc8    = ifid_pc_q + 32'd8;
    assign ifid_valid  = valid_q;
    assign ifid_adel   = adel_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: directed steps from the fetch-stage scenarios plus a random phase,
// each edge compared against a behavioural model of the fetch rules.
module tb_if_pc_stage;

    localparam logic [31:0] TEXT = 32'h0000_3000;
    localparam logic [31:0] IMSZ = 32'h0000_1000;
    localparam logic [31:0] EXCV = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc, instr_in, epc;
    logic        stall, exc_req, eret;
    logic [31:0] pc, ifid_instr, ifid_pc, ifid_pc8, fetch_count;
    logic        ifid_valid, ifid_adel, halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_ifid_pc, m_cnt;
    logic        m_valid, m_adel, m_halt;

    if_pc_stage #(
        .TEXT_STARTADDR(TEXT),
        .IM_SIZE       (IMSZ),
        .EXC_HANDLER   (EXCV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .instr_in   (instr_in),
        .stall      (stall),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .pc         (pc),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc8   (ifid_pc8),
        .ifid_valid (ifid_valid),
        .ifid_adel  (ifid_adel),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = TEXT; m_instr = 0; m_ifid_pc = 0; m_cnt = 0;
        m_valid = 0; m_adel = 0; m_halt = 0;
    endtask

    // One clock edge of the fetch rules, highest priority first.
    task automatic model_edge();
        if (exc_req || eret) begin
            m_ifid_pc = m_pc;
            m_instr = 0; m_valid = 0; m_adel = 0; m_halt = 0;
            m_pc = exc_req ? EXCV : epc;
        end else if (m_halt || m_pc >= TEXT + IMSZ) begin
            m_halt = 1; m_instr = 0; m_valid = 0; m_adel = 0;
        end else if (!stall) begin
            m_ifid_pc = m_pc;
            m_valid = 1;
            if (m_pc % 4 != 0 || m_pc < TEXT) begin
                m_instr = 0; m_adel = 1;
            end else begin
                m_instr = instr_in; m_adel = 0;
            end
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_pc = npc;
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ".pc"}, pc, m_pc);
        chk({step, ".ifid_instr"}, ifid_instr, m_instr);
        chk({step, ".ifid_pc"}, ifid_pc, m_ifid_pc);
        chk({step, ".ifid_pc8"}, ifid_pc8, m_ifid_pc + 32'd8);
        chk({step, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        chk({step, ".ifid_adel"}, {31'b0, ifid_adel}, {31'b0, m_adel});
        chk({step, ".halted"}, {31'b0, halted}, {31'b0, m_halt});
        chk({step, ".fetch_count"}, fetch_count, m_cnt);
    endtask

    task automatic drive(input logic [31:0] n, input logic [31:0] ins, input logic st,
                         input logic ex, input logic er, input logic [31:0] ep);
        npc = n; instr_in = ins; stall = st; exc_req = ex; eret = er; epc = ep;
    endtask

    task automatic tick(input string step);
        @(posedge clk);
        model_edge();
        #1;
        check_all(step);
    endtask

    task automatic adv(input string step);
        drive(m_pc + 4, m_pc, 0, 0, 0, 0);
        tick(step);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        chk("reset.pc_const", pc, 32'h3000);
        @(negedge clk);
        reset = 1'b1;

        // Free run
        adv("run0");
        adv("run1");
        adv("run2");
        chk("run.ifid_pc3", ifid_pc, 32'h3008);
        chk("run.pc8", ifid_pc8, 32'h3010);
        chk("run.count3", fetch_count, 32'd3);

        // Stall for two edges, then resume
        drive(m_pc + 4, m_pc, 1, 0, 0, 0);
        tick("stall0");
        tick("stall1");
        chk("stall.pc_held", pc, 32'h300C);
        chk("stall.count_held", fetch_count, 32'd3);
        adv("resume");
        chk("resume.pc", pc, 32'h3010);

        // exc_req with stall
        drive(m_pc + 4, m_pc, 1, 1, 0, 0);
        tick("exc_stall");
        chk("exc_stall.pc", pc, 32'h4180);
        chk("exc_stall.count", fetch_count, 32'd4);

        // eret, then eret with exc_req
        drive(0, 0, 0, 0, 1, 32'h3020);
        tick("eret");
        chk("eret.pc", pc, 32'h3020);
        drive(0, 0, 0, 1, 1, 32'h3020);
        tick("eret_exc");
        chk("eret_exc.pc", pc, 32'h4180);
        drive(0, 0, 0, 0, 1, 32'h3000);
        tick("eret_back");

        // Misaligned and below-text fetches
        drive(32'h3006, 32'hDEAD_BEEF, 0, 0, 0, 0);
        tick("mis_set");
        drive(32'h2FFC, 32'h1234_5678, 0, 0, 0, 0);
        tick("mis_fetch");
        chk("mis.adel", {31'b0, ifid_adel}, 32'd1);
        chk("mis.instr", ifid_instr, 32'h0);
        drive(32'h3000, 32'h1111_2222, 0, 0, 0, 0);
        tick("low_fetch");
        chk("low.adel", {31'b0, ifid_adel}, 32'd1);

        // Run to end of text
        drive(32'h3FFC, 32'h0, 0, 0, 0, 0);
        tick("end_set");
        adv("end_last");
        chk("end.pc", pc, 32'h4000);
        adv("halt_enter");
        chk("halt.halted", {31'b0, halted}, 32'd1);
        chk("halt.pc", pc, 32'h4000);
        adv("halt_stay");
        drive(0, 0, 1, 1, 0, 0);
        tick("halt_exc");
        chk("halt_exc.halted", {31'b0, halted}, 32'd0);
        chk("halt_exc.pc", pc, 32'h4180);
        drive(0, 0, 0, 0, 1, 32'h3000);
        tick("to_text");

        // Random phase
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] n, ep;
            r = $urandom_range(0, 99);
            if (r < 75) n = m_pc + 4;
            else if (r < 85) n = TEXT + ($urandom_range(0, 1023) << 2);
            else if (r < 92) n = TEXT + $urandom_range(0, 4095);
            else if (r < 96) n = TEXT - ($urandom_range(1, 16) << 2);
            else n = TEXT + IMSZ - ($urandom_range(0, 2) << 2);
            ep = TEXT + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 1) * 2;
            drive(n, $urandom, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 4, ep);
            tick("rand");
        end

        // Asynchronous reset mid-run
        drive(m_pc + 4, 32'hCAFE_F00D, 1, 0, 0, 0);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        chk("mid_reset.pc", pc, 32'h3000);
        chk("mid_reset.count", fetch_count, 32'd0);
        #1;
        reset = 1'b1;
        adv("post_reset");
        chk("post_reset.ifid_pc", ifid_pc, 32'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
